seq_div_unit: RTL and testbench

Multi-cycle signed restoring divider that sits directly downstream of the Y register and the internal bus, and feeds the Z register pair.
- Y supplies the dividend; the bus supplies the divisor.
- Quotient goes to ZLo and remainder to ZHi, so the existing ZLo→Lo and ZHi→Hi transfer steps work unchanged.
- Replaces the single-cycle DIV path (ALU code 5'b01111). The control sequence holds in the ZIn step until done.

---
 rtl/seq_div_pkg.sv | 6 +
 rtl/div_restore_step.sv | 19 +
 rtl/seq_div_unit.sv | 113 +++++++++++
 tb/tb_seq_div_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state encoding, datapath width and ALU code for the sequential divider.
package seq_div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam logic [4:0] ALU_DIV = 5'b01111;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one combinational restoring-division step on the {rem,quo} pair.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] sh, diff;
  logic ge;
  // rem < dvs, so the shifted value needs one extra bit and the difference never underflows past it
  assign sh = {rem_i, quo_i[WIDTH-1]};
  assign diff = sh - {1'b0, dvs_i};
  assign ge = ~diff[WIDTH];
  assign rem_o = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ge};
endmodule

// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle signed restoring divider, Y/bus in, quotient->ZLo, remainder->ZHi.
// Define SEQ_DIV_UNSIGNED_EN to add the div_unsigned input (DIVU semantics).
module seq_div_unit
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_UNSIGNED_EN
  input  logic             div_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
  logic sq_q, sq_d, sr_q, sr_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic uns, neg_a, neg_b;
  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q), .quo_i(quo_q), .dvs_i(dvs_q), .rem_o(step_rem), .quo_o(step_quo)
  );
`ifdef SEQ_DIV_UNSIGNED_EN
  assign uns = div_unsigned;
`else
  assign uns = 1'b0;
`endif
  assign neg_a = dividend[WIDTH-1] & ~uns;
  assign neg_b = divisor[WIDTH-1] & ~uns;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    sq_d = sq_q;
    sr_d = sr_q;
    dbz_d = dbz_q;
    quot_d = quot_q;
    remo_d = remo_q;
    unique case (state_q)
      IDLE: if (start) begin
        if (divisor == '0) begin
          state_d = DONE;
          quot_d = '1;
          remo_d = dividend;
          dbz_d = 1'b1;
        end else begin
          state_d = CALC;
          cnt_d = '0;
          rem_d = '0;
          quo_d = neg_a ? -dividend : dividend;
          dvs_d = neg_b ? -divisor : divisor;
          sq_d = neg_a ^ neg_b;
          sr_d = neg_a;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : CALC;
      end
      FIX: begin
        quot_d = sq_q ? -quo_q : quo_q;
        remo_d = sr_q ? -rem_q : rem_q;
        dbz_d = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      dbz_q <= 1'b0;
      quot_q <= '0;
      remo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      dbz_q <= dbz_d;
      quot_q <= quot_d;
      remo_q <= remo_d;
    end
  end
  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = state_q == DONE;
  assign div_by_zero = dbz_q;
  assign quotient = quot_q;
  assign remainder = remo_q;
endmodule

// File: tb/tb_seq_div_unit.sv
// tb_seq_div_unit: randomized scoreboard bench for seq_div_unit against a plain-arithmetic model.
module tb_seq_div_unit;
  logic clock = 1'b0, clear = 1'b1, start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
`ifdef SEQ_DIV_UNSIGNED_EN
  logic div_unsigned = 1'b0;
`endif
  logic busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          t;
    int          nbusy;
  } exp_t;
  exp_t scb[$];

  seq_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .clear(clear), .start(start), .dividend(dividend), .divisor(divisor),
`ifdef SEQ_DIV_UNSIGNED_EN
    .div_unsigned(div_unsigned),
`endif
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .quotient(quotient), .remainder(remainder)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) begin
      e.q = '1; e.r = a; e.z = 1'b1; e.nbusy = 0;
    end else begin
      e.q = 32'(sa / sb); e.r = 32'(sa % sb); e.z = 1'b0; e.nbusy = 33;
    end
    e.t = 0;
    return e;
  endfunction

  initial begin : monitor
    int bcnt;
    exp_t e;
    bcnt = 0;
    forever begin
      @(negedge clock);
      if (clear) bcnt = 0;
      else begin
        if (busy) bcnt++;
        if (done) begin
          if (scb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
          end else begin
            e = scb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
            chk("done_cycle", cyc, e.t);
            chk("busy_cycles", bcnt, e.nbusy);
          end
          bcnt = 0;
        end
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    exp_t e;
    @(negedge clock);
    dividend = a;
    divisor = b;
    start = 1'b1;
    if (expect_result) begin
      e = model(a, b);
      e.t = cyc + 1 + e.nbusy;
      scb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && scb.size() != 0; i++) @(negedge clock);
    if (scb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", scb.size());
      scb.delete();
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b);
    launch(a, b, 1'b1);
    drain();
  endtask

  task automatic chk_idle_zero(input string n);
    chk({n, "_q"}, quotient, 32'h0);
    chk({n, "_r"}, remainder, 32'h0);
    chk({n, "_flags"}, {29'b0, busy, done, div_by_zero}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (3) @(negedge clock);
    clear = 1'b0;
    chk_idle_zero("reset");
    op(32'd100, 32'd7);
    op(-32'sd15, 32'sd6);
    op(32'd6, -32'sd15);
    op(32'h8000_0000, 32'hFFFF_FFFF);
    op(-32'sd7, -32'sd2);
    op(32'd42, 32'd0);
    launch(32'd100, 32'd7, 1'b1);
    repeat (8) @(negedge clock);
    dividend = 32'd9;
    divisor = 32'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dividend = 32'd55;
    divisor = 32'd5;
    drain();
    launch(32'd100, 32'd7, 1'b0);
    repeat (18) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk_idle_zero("abort");
    repeat (40) @(negedge clock);
    chk_idle_zero("abort_quiet");
    op(32'd9, 32'd3);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9)) * (($urandom & 1) != 0 ? 32'hFFFF_FFFF : 32'd1);
        2: a = 32'h8000_0000;
        3: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      op(a, b);
    end
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
